// File: rtl/weight_mem_writer.sv
// Weight loader: neuron-major word stream -> one-hot write enable, address and data for per-neuron weight memories.
// Latency: accepted beat is presented on wen/waddr/wdata the next cycle; one word per cycle.
// Backpressure: s_ready high only while loading; drops after the final or s_last beat. Optional checksum port via WEIGHT_WRITER_CHECKSUM_EN.
module weight_mem_writer #(
    parameter int numNeurons   = 30,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_last,
    output logic [numNeurons-1:0]   wen,
    output logic [addressWidth:0]   waddr,
    output logic [dataWidth-1:0]    wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err
`ifdef WEIGHT_WRITER_CHECKSUM_EN
    ,
    output logic [31:0]             checksum
`endif
);

    localparam int NW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [NW-1:0]        N_LAST = NW'(numNeurons - 1);
    localparam logic [addressWidth:0] W_LAST = (addressWidth + 1)'(numWeight - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t                  state;
    logic [addressWidth:0]   w;
    logic [NW-1:0]           n;
    logic                    beat;
    logic                    last_w;
    logic                    final_beat;

    // s_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign beat       = s_valid && s_ready;
    assign last_w     = (w == W_LAST);
    assign final_beat = last_w && (n == N_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wen     <= '0;
            waddr   <= '0;
            wdata   <= '0;
            w       <= '0;
            n       <= '0;
        end else begin
            wen  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        w       <= '0;
                        n       <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wen   <= numNeurons'(1) << n;
                        waddr <= w;
                        wdata <= s_data;
                        if (last_w) begin
                            w <= '0;
                            n <= n + 1'b1;
                        end else begin
                            w <= w + 1'b1;
                        end
                        // Early s_last still writes its word, but the layer is flagged bad.
                        if (final_beat || s_last) begin
                            state   <= FLUSH;
                            s_ready <= 1'b0;
                            done    <= final_beat && s_last;
                            err     <= !(final_beat && s_last);
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHT_WRITER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (beat) begin
            checksum <= checksum + 32'(s_data);
        end
    end
`endif

endmodule

// File: tb/tb_weight_mem_writer.sv
// Scoreboard bench for weight_mem_writer: accepted beats queue the expected write, popped when wen is presented.
module tb_weight_mem_writer;
    localparam int NN  = 2;
    localparam int NWT = 4;
    localparam int AW  = 2;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, s_valid, s_last;
    logic          s_ready, busy, done, err;
    logic [DW-1:0] s_data, wdata;
    logic [NN-1:0] wen;
    logic [AW:0]   waddr;
`ifdef WEIGHT_WRITER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    always #5 clk = ~clk;

    weight_mem_writer #(
        .numNeurons(NN), .numWeight(NWT), .addressWidth(AW), .dataWidth(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err)
`ifdef WEIGHT_WRITER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    typedef struct packed {
        logic [NN-1:0] wen;
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         sb[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          mw = 0;
    int          mn = 0;
    bit          m_active = 0;
    bit          mon_en = 0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] m_sum = 0;
    logic [31:0] sum_at_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check what the DUT presents this cycle, then model what the next posedge will do.
    always @(negedge clk) begin
        wr_t e;
        bit  acc, fin;
        if (mon_en) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wen", 32'(wen), 32'(e.wen));
                chk("waddr", 32'(waddr), 32'(e.addr));
                chk("wdata", 32'(wdata), 32'(e.data));
            end else begin
                chk("wen_quiet", 32'(wen), 0);
            end
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(exp_err));
            if (prev_done) chk("busy_after_done", 32'(busy), 0);
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 1);
`ifdef WEIGHT_WRITER_CHECKSUM_EN
                chk("checksum_model", checksum, m_sum);
                sum_at_done = checksum;
`endif
            end
            prev_done = done;

            acc = rst_n && s_valid && s_ready;
            fin = acc && (mn == NN - 1) && (mw == NWT - 1);
            exp_done = fin && s_last;
            if (!rst_n) begin
                exp_err = 1'b0; m_active = 0; mw = 0; mn = 0; m_sum = 0;
            end else if (start && !m_active) begin
                exp_err = 1'b0; m_active = 1; mw = 0; mn = 0; m_sum = 0;
            end else if (acc) begin
                e.wen  = NN'(1) << mn;
                e.addr = (AW + 1)'(mw);
                e.data = s_data;
                sb.push_back(e);
                m_sum = m_sum + 32'(s_data);
                if (fin || s_last) begin
                    exp_err  = !(fin && s_last);
                    m_active = 0;
                end
                if (mw == NWT - 1) begin
                    mw = 0;
                    mn++;
                end else begin
                    mw++;
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        int budget;
        budget  = 20;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            budget--;
            if (budget == 0) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic load(input int nw, input int last_at, input int gap, input bit ones);
        for (int i = 0; i < nw; i++) begin
            send(ones ? 16'hFFFF : DW'(i + 1), (i + 1) == last_at);
            if (gap > 0 && i < nw - 1) cyc(gap);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        cyc(2);
        mon_en = 1;
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_wen", 32'(wen), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        cyc(2);

        // clean continuous load
        d0 = done_cnt;
        pulse_start;
        chk("ready_after_start", 32'(s_ready), 1);
        load(8, 8, 0, 0);
        chk("ready_drop", 32'(s_ready), 0);
        chk("busy_flush", 32'(busy), 1);
        cyc(3);
        chk("clean_done_cnt", done_cnt - d0, 1);
        chk("clean_err", 32'(err), 0);
        chk("clean_busy", 32'(busy), 0);
`ifdef WEIGHT_WRITER_CHECKSUM_EN
        chk("checksum_clean", sum_at_done, 36);
`endif

        // s_valid toggling, with a start pulse mid-load that must be ignored
        d0 = done_cnt;
        pulse_start;
        for (int i = 0; i < 8; i++) begin
            start = (i == 2);
            send(DW'(i + 1), i == 7);
            start = 1'b0;
            if (i < 7) cyc(1);
        end
        cyc(3);
        chk("toggle_done_cnt", done_cnt - d0, 1);
        chk("toggle_err", 32'(err), 0);

        // early s_last on 5th word
        d0 = done_cnt;
        pulse_start;
        load(5, 5, 0, 0);
        cyc(1);
        chk("early_err", 32'(err), 1);
        s_valid = 1'b1; s_data = 16'h00AA;
        cyc(4);
        s_valid = 1'b0;
        chk("early_ready", 32'(s_ready), 0);
        chk("early_busy", 32'(busy), 0);
        chk("early_done_cnt", done_cnt - d0, 0);

        // missing s_last on final word
        d0 = done_cnt;
        pulse_start;
        load(8, 0, 0, 0);
        cyc(2);
        chk("nolast_err", 32'(err), 1);
        chk("nolast_done_cnt", done_cnt - d0, 0);
        pulse_start;
        chk("start_clears_err", 32'(err), 0);

        // reset after 3 accepted beats
        load(3, 0, 0, 0);
        rst_n = 1'b0;
        cyc(1);
        chk("mid_rst_ready", 32'(s_ready), 0);
        chk("mid_rst_wen", 32'(wen), 0);
        chk("mid_rst_waddr", 32'(waddr), 0);
        chk("mid_rst_wdata", 32'(wdata), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(err), 0);
        rst_n = 1'b1;
        cyc(1);
        d0 = done_cnt;
        pulse_start;
        load(8, 8, 0, 0);
        cyc(3);
        chk("restart_done_cnt", done_cnt - d0, 1);

`ifdef WEIGHT_WRITER_CHECKSUM_EN
        pulse_start;
        load(8, 8, 0, 1);
        cyc(3);
        chk("checksum_ffff", sum_at_done, 32'h0007FFF8);
`endif

        cyc(2);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
